// File: rtl/video_timing_pkg.sv
// Shared video timing defaults and the line-recovery FSM state type.
// Used by the hsync recovery block, and later by the vsync recovery block.
package video_timing_pkg;

  localparam int W_DEF          = 11;
  localparam int ACTIVE_DEF     = 800;
  localparam int SYNC_START_DEF = 856;
  localparam int LINE_TOTAL_DEF = 1041;
  localparam int LOCK_LINES_DEF = 4;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } rec_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser plus one delay stage for an asynchronous level input.
// Produces the synchronised level and single-cycle fall/rise strobes.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic cur_o,
  output logic fall_o,
  output logic rise_o
);

  logic meta_q;
  logic cur_q;
  logic prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      cur_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= sig_i;
      cur_q  <= meta_q;
      prev_q <= cur_q;
    end
  end

  assign cur_o  = cur_q;
  assign fall_o = prev_q & ~cur_q;
  assign rise_o = ~prev_q & cur_q;

endmodule

// File: rtl/hsync_timing_recovery.sv
// Measures the incoming hsync period and pulse width, locks once the period is
// stable, and regenerates xpos / disp_active / newline aligned to the incoming line.
module hsync_timing_recovery
  import video_timing_pkg::*;
#(
  parameter int ACTIVE     = ACTIVE_DEF,
  parameter int SYNC_START = SYNC_START_DEF,
  parameter int LOCK_LINES = LOCK_LINES_DEF,
  parameter int W          = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hsync_in,
  output logic [W-1:0] line_total,
  output logic [W-1:0] sync_width,
  output logic         locked,
  output logic         timeout,
  output logic [W-1:0] xpos,
  output logic         disp_active,
  output logic         newline
);

  localparam int           MW         = $clog2(LOCK_LINES + 1);
  localparam logic [W-1:0] CNT_MAX    = '1;
  localparam logic [W-1:0] XPOS_LOAD  = W'(SYNC_START);
  localparam logic [W-1:0] ACTIVE_W   = W'(ACTIVE);
  localparam logic [MW-1:0] MATCH_LOCK = MW'(LOCK_LINES);

  logic cur;
  logic fall;
  logic rise;

  sync_edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (hsync_in),
    .cur_o  (cur),
    .fall_o (fall),
    .rise_o (rise)
  );

  logic [W-1:0]  period_cnt_q, period_cnt_d;
  logic [W-1:0]  low_cnt_q, low_cnt_d;
  logic [W-1:0]  sync_width_q, sync_width_d;
  logic          timeout_q, timeout_d;
  rec_state_e    state_q;
  logic [W-1:0]  ref_q;
  logic [MW-1:0] match_q;
  logic [W-1:0]  line_total_q;
  logic          locked_q, locked_d;
  logic [W-1:0]  xpos_q, xpos_d;
  logic          disp_q, disp_d;
  logic          newline_q, newline_d;

  logic          sat;
  logic          timeout_evt;
  logic [MW-1:0] match_nxt;
  logic          lock_set;
  logic          lock_drop;
  logic [W-1:0]  xpos_last;
  logic          wrap;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    sat          = (period_cnt_q == CNT_MAX);
    timeout_evt  = sat & ~fall;

    period_cnt_d = period_cnt_q;
    if (fall)      period_cnt_d = W'(1);
    else if (!sat) period_cnt_d = period_cnt_q + 1'b1;

    low_cnt_d = low_cnt_q;
    if (fall)                            low_cnt_d = W'(1);
    else if (!cur && low_cnt_q != CNT_MAX) low_cnt_d = low_cnt_q + 1'b1;

    sync_width_d = rise ? low_cnt_q : sync_width_q;

    timeout_d = timeout_q;
    if (fall)     timeout_d = 1'b0;
    else if (sat) timeout_d = 1'b1;

    // Candidate period is period_cnt_q, sampled on the fall strobe.
    match_nxt = (period_cnt_q == ref_q) ? match_q + 1'b1 : MW'(1);
    lock_set  = fall && (state_q == MEASURE) && (match_nxt == MATCH_LOCK);
    lock_drop = fall && (state_q == LOCKED) && (period_cnt_q != line_total_q);
    locked_d  = !timeout_evt && (lock_set || (locked_q && !lock_drop));

    // Before the first lock line_total is 0, so xpos_last is all-ones and
    // xpos simply wraps at 2^W.
    xpos_last = line_total_q - 1'b1;
    wrap      = !fall && (xpos_q == xpos_last);
    xpos_d    = xpos_q + 1'b1;
    if (fall)      xpos_d = XPOS_LOAD;
    else if (wrap) xpos_d = '0;

    disp_d    = locked_d && (xpos_d < ACTIVE_W);
    newline_d = locked_d && wrap;
  end

  // NOTE: all measurement and timing registers are reset, so a reset mid-line
  // discards any partial measurement instead of carrying stale state forward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt_q <= '0;
      low_cnt_q    <= '0;
      sync_width_q <= '0;
      timeout_q    <= 1'b0;
      xpos_q       <= '0;
      disp_q       <= 1'b0;
      newline_q    <= 1'b0;
    end else begin
      period_cnt_q <= period_cnt_d;
      low_cnt_q    <= low_cnt_d;
      sync_width_q <= sync_width_d;
      timeout_q    <= timeout_d;
      xpos_q       <= xpos_d;
      disp_q       <= disp_d;
      newline_q    <= newline_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SEARCH;
      ref_q        <= '0;
      match_q      <= '0;
      line_total_q <= '0;
      locked_q     <= 1'b0;
    end else begin
      locked_q <= locked_d;
      if (timeout_evt) begin
        state_q <= SEARCH;
      end else if (fall) begin
        case (state_q)
          SEARCH: begin
            // The interval before the first edge is unknown; capture nothing.
            state_q <= MEASURE;
            ref_q   <= '0;
            match_q <= '0;
          end
          MEASURE: begin
            ref_q   <= period_cnt_q;
            match_q <= match_nxt;
            if (lock_set) begin
              state_q      <= LOCKED;
              line_total_q <= period_cnt_q;
            end
          end
          LOCKED: begin
            if (lock_drop) begin
              state_q <= MEASURE;
              ref_q   <= period_cnt_q;
              match_q <= MW'(1);
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign line_total  = line_total_q;
  assign sync_width  = sync_width_q;
  assign locked      = locked_q;
  assign timeout     = timeout_q;
  assign xpos        = xpos_q;
  assign disp_active = disp_q;
  assign newline     = newline_q;

endmodule

// File: tb/tb_hsync_timing_recovery.sv
// Directed bench for hsync_timing_recovery: lock, recovered timing, period
// change, timeout, mid-line reset and alternating periods.
module tb_hsync_timing_recovery;
  import video_timing_pkg::*;

  localparam int W   = W_DEF;
  localparam int LT  = LINE_TOTAL_DEF;
  localparam int LOW = 120;

  logic         clk = 1'b0;
  logic         rst;
  logic         hsync_in;
  logic [W-1:0] line_total;
  logic [W-1:0] sync_width;
  logic         locked;
  logic         timeout;
  logic [W-1:0] xpos;
  logic         disp_active;
  logic         newline;

  int checks   = 0;
  int failures = 0;

  int           disp_cnt, disp_rises, nl_cnt, nl_at, lock_cycles, match_max;
  logic [W-1:0] x_at2, x_at3;
  logic         disp_prev = 1'b0;

  hsync_timing_recovery dut (
    .clk         (clk),
    .rst         (rst),
    .hsync_in    (hsync_in),
    .line_total  (line_total),
    .sync_width  (sync_width),
    .locked      (locked),
    .timeout     (timeout),
    .xpos        (xpos),
    .disp_active (disp_active),
    .newline     (newline)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One line: pin low for 'low' cycles from index 0, then high; observe each cycle.
  task automatic run_line(input int period, input int low);
    disp_cnt = 0; disp_rises = 0; nl_cnt = 0; nl_at = -1; lock_cycles = 0;
    for (int i = 0; i < period; i++) begin
      hsync_in = (i < low) ? 1'b0 : 1'b1;
      tick();
      if (disp_active) begin
        disp_cnt++;
        if (!disp_prev) disp_rises++;
      end
      disp_prev = disp_active;
      if (newline) begin nl_cnt++; nl_at = i; end
      if (locked) lock_cycles++;
      if (i == 2) x_at2 = xpos;
      if (i == 3) x_at3 = xpos;
      if (int'(dut.match_q) > match_max) match_max = int'(dut.match_q);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; hsync_in = 1'b1;
    repeat (5) tick();
    checks++;
    if ({locked, timeout, disp_active, newline} !== 4'b0000 || line_total !== '0 ||
        sync_width !== '0 || xpos !== '0) begin
      failures++;
      $display("FAIL reset_state: locked=%0b timeout=%0b disp=%0b nl=%0b lt=%0d sw=%0d xpos=%0d want all 0",
               locked, timeout, disp_active, newline, line_total, sync_width, xpos);
    end
    rst = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_lock();
    for (int n = 1; n <= 5; n++) begin
      run_line(LT, LOW);
      if (n == 4) begin
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL lock_not_4th: locked=%0b want 0", locked); end
      end
    end
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL lock_5th: locked=%0b want 1", locked); end
    checks++;
    if (line_total !== W'(LT)) begin failures++; $display("FAIL lock_line_total: got %0d want %0d", line_total, LT); end
    checks++;
    if (sync_width !== W'(LOW)) begin failures++; $display("FAIL lock_sync_width: got %0d want %0d", sync_width, LOW); end
  endtask

  task automatic test_xpos();
    for (int n = 0; n < 2; n++) begin
      run_line(LT, LOW);
      checks++;
      if (x_at2 !== W'(SYNC_START_DEF) || x_at3 !== W'(SYNC_START_DEF + 1)) begin
        failures++;
        $display("FAIL xpos_load: got %0d,%0d want %0d,%0d", x_at2, x_at3, SYNC_START_DEF, SYNC_START_DEF + 1);
      end
      checks++;
      if (nl_cnt !== 1 || nl_at !== 187) begin
        failures++; $display("FAIL newline: count=%0d at=%0d want 1 at 187", nl_cnt, nl_at);
      end
      checks++;
      if (disp_cnt !== ACTIVE_DEF || disp_rises !== 1) begin
        failures++; $display("FAIL disp_active: cycles=%0d runs=%0d want %0d in 1 run", disp_cnt, disp_rises, ACTIVE_DEF);
      end
    end
  endtask

  task automatic test_period_change();
    run_line(LT - 1, LOW);
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL short_line_pre: locked=%0b want 1", locked); end
    for (int n = 1; n <= 5; n++) begin
      run_line(LT, LOW);
      if (n == 1) begin
        checks++;
        if (locked !== 1'b0 || line_total !== W'(LT)) begin
          failures++; $display("FAIL short_line_drop: locked=%0b lt=%0d want 0, %0d", locked, line_total, LT);
        end
      end
      if (n == 4) begin
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL relock_early: locked=%0b want 0", locked); end
      end
    end
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL relock: locked=%0b want 1", locked); end
  endtask

  task automatic test_timeout();
    for (int k = 1; k <= LOW + 2100; k++) begin
      hsync_in = (k <= LOW) ? 1'b0 : 1'b1;
      tick();
      if (k == 2049) begin
        checks++;
        if (timeout !== 1'b0 || locked !== 1'b1) begin
          failures++; $display("FAIL timeout_early: timeout=%0b locked=%0b want 0,1", timeout, locked);
        end
      end
      if (k == 2050) begin
        checks++;
        if (timeout !== 1'b1 || locked !== 1'b0) begin
          failures++; $display("FAIL timeout_set: timeout=%0b locked=%0b want 1,0", timeout, locked);
        end
      end
    end
    checks++;
    if (timeout !== 1'b1 || line_total !== W'(LT)) begin
      failures++; $display("FAIL timeout_hold: timeout=%0b lt=%0d want 1, %0d", timeout, line_total, LT);
    end
    for (int n = 1; n <= 5; n++) begin
      run_line(LT, LOW);
      if (n == 1) begin
        checks++;
        if (timeout !== 1'b0 || locked !== 1'b0) begin
          failures++; $display("FAIL timeout_clear: timeout=%0b locked=%0b want 0,0", timeout, locked);
        end
      end
      if (n == 4) begin
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL timeout_relock_early: locked=%0b want 0", locked); end
      end
    end
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL timeout_relock: locked=%0b want 1", locked); end
  endtask

  task automatic test_reset_midline();
    for (int i = 0; i < 500; i++) begin
      hsync_in = (i < LOW) ? 1'b0 : 1'b1;
      tick();
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({locked, timeout, disp_active, newline} !== 4'b0000 || line_total !== '0 ||
        sync_width !== '0 || xpos !== '0) begin
      failures++;
      $display("FAIL async_reset: locked=%0b timeout=%0b disp=%0b nl=%0b lt=%0d sw=%0d xpos=%0d want all 0",
               locked, timeout, disp_active, newline, line_total, sync_width, xpos);
    end
    for (int i = 500; i < LT; i++) begin
      hsync_in = (i < LOW) ? 1'b0 : 1'b1;
      tick();
    end
    // This line's falling edge happens inside reset and is not seen.
    for (int i = 0; i < LT; i++) begin
      hsync_in = (i < LOW) ? 1'b0 : 1'b1;
      tick();
      if (i == 50) rst = 1'b0;
    end
    for (int n = 2; n <= 6; n++) begin
      run_line(LT, LOW);
      if (n == 5) begin
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL rst_relock_early: locked=%0b want 0", locked); end
      end
    end
    checks++;
    if (locked !== 1'b1 || line_total !== W'(LT) || sync_width !== W'(LOW)) begin
      failures++;
      $display("FAIL rst_relock: locked=%0b lt=%0d sw=%0d want 1, %0d, %0d", locked, line_total, sync_width, LT, LOW);
    end
  endtask

  task automatic test_alternating();
    for (int n = 0; n < 8; n++) begin
      if (n == 2) match_max = 0;
      run_line((n % 2 == 0) ? LT + 1 : LT, LOW);
      if (n >= 2) begin
        checks++;
        if (lock_cycles !== 0) begin
          failures++; $display("FAIL alt_locked: line %0d locked for %0d cycles want 0", n, lock_cycles);
        end
      end
    end
    checks++;
    if (match_max !== 1 || line_total !== W'(LT)) begin
      failures++; $display("FAIL alt_match: max_match=%0d lt=%0d want 1, %0d", match_max, line_total, LT);
    end
  endtask

  initial begin
    match_max = 0;
    test_reset();
    test_lock();
    test_xpos();
    test_period_change();
    test_timeout();
    test_reset_midline();
    test_alternating();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
